// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V core memories.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned DMEM_DEPTH = 1024;
  localparam int unsigned DMEM_AW    = $clog2(DMEM_DEPTH);

  typedef logic [XLEN-1:0] word_t;

endpackage : riscv_pkg

// File: rtl/ram_1p_async.sv
// Generic single-port RAM: synchronous write, combinational read.
// Kept free of reset logic so it maps onto distributed/block RAM and can be
// reused for IMEM.
module ram_1p_async #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 1024,
  localparam int unsigned Aw   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  // Power-up contents are all zero; nothing ever clears them afterwards.
  logic [Width-1:0] mem_q [Depth] = '{default: '0};

  // Write port: one full word per enabled edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read port: purely combinational, zero latency.
  always_comb begin
    rdata_o = mem_q[addr_i];
  end

endmodule : ram_1p_async

// File: rtl/dmem.sv
// Data memory for the single-cycle load/store path: word addressed,
// synchronous write, asynchronous read. Reset only blocks writes; it never
// touches the stored contents.
module dmem
  import riscv_pkg::*;
#(
  parameter int unsigned size      = XLEN,
  parameter int unsigned mem_depth = DMEM_DEPTH,
  localparam int unsigned Aw       = (mem_depth > 1) ? $clog2(mem_depth) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wren,
  input  logic [Aw-1:0]   address,
  input  logic [size-1:0] data_in,
  output logic [size-1:0] data_out
);

  // One past the last valid word, widened so the compare never wraps.
  localparam logic [Aw:0] DepthLim = (Aw + 1)'(mem_depth);

  logic            in_range;
  logic            we_d;
  logic [size-1:0] rdata;

  // Address qualification; only matters for non-power-of-two depths.
  always_comb begin
    in_range = ({1'b0, address} < DepthLim);
  end

  // Effective write strobe: reset and out-of-range addresses suppress it.
  always_comb begin
    we_d = wren & ~reset & in_range;
  end

  ram_1p_async #(
    .Width (size),
    .Depth (mem_depth)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (we_d),
    .addr_i  (address),
    .wdata_i (data_in),
    .rdata_o (rdata)
  );

  // Read mux: words beyond the array read as zero.
  always_comb begin
    data_out = in_range ? rdata : '0;
  end

  // Unknown control on a live edge could scribble an arbitrary word.
  a_ctrl_known : assert property (@(posedge clock) !reset |-> !$isunknown({wren, address}));

endmodule : dmem

// File: tb/tb_dmem.sv
// Self-checking bench for dmem: directed load/store scenarios followed by a
// short randomised phase against a reference array.
module tb_dmem;
  import riscv_pkg::*;

  logic                 clock;
  logic                 reset;
  logic                 wren;
  logic [DMEM_AW-1:0]   address;
  word_t                data_in;
  word_t                data_out;

  int unsigned n_checks;
  int unsigned n_errors;

  // Reference contents and the expected-read scoreboard.
  word_t model [DMEM_DEPTH];
  word_t exp_q [$];
  string tag_q [$];

  dmem u_dut (
    .clock    (clock),
    .reset    (reset),
    .wren     (wren),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Set inputs away from the active edge.
  task automatic drive(input logic rst, input logic we, input logic [DMEM_AW-1:0] a,
                       input word_t d);
    @(negedge clock);
    reset   = rst;
    wren    = we;
    address = a;
    data_in = d;
  endtask

  // Take one rising edge and update the reference with what should be stored.
  task automatic tick();
    @(posedge clock);
    if (!reset && wren) model[address] = data_in;
    #1;
  endtask

  // Queue an expected read, let the combinational path settle, then compare.
  task automatic sample(input string tag, input word_t exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    check_eq(tag_q.pop_front(), data_out, exp_q.pop_front());
  endtask

  logic [DMEM_AW-1:0] ra;
  word_t              rd;
  logic               rw;
  logic               rr;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    wren     = 1'b0;
    address  = '0;
    data_in  = '0;
    for (int i = 0; i < DMEM_DEPTH; i++) model[i] = '0;

    // Reset state: contents zero, output follows the array during reset.
    tick();
    tick();
    sample("reset_addr0", 32'd0);
    drive(1'b1, 1'b0, 10'd1, 32'd0);
    sample("reset_addr1", 32'd0);

    // Write 53 to addr 1 on four edges, then hold address with wren low.
    drive(1'b0, 1'b1, 10'd1, 32'd53);
    repeat (4) tick();
    drive(1'b0, 1'b0, 10'd1, 32'd0);
    sample("wr53_rd1", 32'd53);

    // Two different words.
    drive(1'b0, 1'b1, 10'd4, 32'd25);
    tick();
    drive(1'b0, 1'b1, 10'd26, 32'd10);
    tick();
    drive(1'b0, 1'b0, 10'd4, 32'd0);
    sample("rd4", 32'd25);
    tick();
    drive(1'b0, 1'b0, 10'd26, 32'd0);
    sample("rd26", 32'd10);

    // Asynchronous read: address changes between edges, no edge taken.
    drive(1'b0, 1'b0, 10'd4, 32'd0);
    sample("async4", 32'd25);
    address = 10'd26;
    sample("async26", 32'd10);
    address = 10'd1;
    sample("async1", 32'd53);

    // Reset blocks writes even with wren high.
    drive(1'b1, 1'b1, 10'd4, 32'hDEADBEEF);
    tick();
    tick();
    sample("rst_blocks_wr", 32'd25);
    drive(1'b0, 1'b1, 10'd4, 32'hDEADBEEF);
    sample("rst_release_pre", 32'd25);
    tick();
    sample("rst_release_wr", 32'hDEADBEEF);

    // Read-during-write at the top word.
    drive(1'b0, 1'b1, 10'd1023, 32'hFFFFFFFF);
    sample("rdw1023_old", 32'd0);
    tick();
    sample("rdw1023_new", 32'hFFFFFFFF);

    // Bottom word, and the top word must be untouched.
    drive(1'b0, 1'b1, 10'd0, 32'hA5A5A5A5);
    tick();
    sample("wr0", 32'hA5A5A5A5);
    drive(1'b0, 1'b0, 10'd1023, 32'd0);
    sample("keep1023", 32'hFFFFFFFF);

    // Consecutive writes keep the last value; rewriting is idempotent.
    drive(1'b0, 1'b1, 10'd7, 32'd1);
    tick();
    data_in = 32'd2;
    tick();
    data_in = 32'd3;
    tick();
    sample("last_wins", 32'd3);
    tick();
    sample("idempotent", 32'd3);

    // Earlier words survived everything above.
    drive(1'b0, 1'b0, 10'd26, 32'd0);
    sample("keep26", 32'd10);
    address = 10'd1;
    sample("keep1", 32'd53);

    // Never-written word.
    address = 10'd500;
    sample("unwritten500", 32'd0);

    // Randomised traffic against the reference array, occasionally in reset.
    for (int i = 0; i < 60; i++) begin
      ra = DMEM_AW'($urandom_range(100, 131));
      rd = $urandom;
      rw = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 7) == 0);
      drive(rr, rw, ra, rd);
      sample("rnd_pre", model[ra]);
      tick();
      sample("rnd_post", model[ra]);
    end
    for (int i = 100; i < 132; i++) begin
      drive(1'b0, 1'b0, DMEM_AW'(i), 32'd0);
      sample("rnd_sweep", model[i]);
    end
    drive(1'b0, 1'b0, 10'd500, 32'd0);
    sample("rnd_untouched", 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dmem
